// File: rtl/nvme_drv_pkg.sv
// Shared NVMe driver types: arbiter FSM states, doorbell IDs and AXI4 encodings.
package nvme_drv_pkg;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} arb_state_e;
  typedef enum logic {DB_SQ = 1'b0, DB_CQ = 1'b1} db_id_e;

  localparam int         NUM_DB         = 2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/doorbell_arbiter.sv
// Arbitrates SQ-tail / CQ-head doorbell requests onto single-beat AXI4 writes with credit limiting.
// Define DB_COALESCE_EN to keep doorbells always ready and write only the newest pending value.
module doorbell_arbiter
  import nvme_drv_pkg::*;
#(
  parameter int NM_ADDR_WIDTH   = 32,
  parameter int NM_DATA_WIDTH   = 128,
  parameter int MAX_OUTSTANDING = 4,
  parameter int SQ_DB_ADDR      = 1008,
  parameter int CQ_DB_ADDR      = 1012
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   sqdb_valid,
  output logic                                   sqdb_ready,
  input  logic [15:0]                            sqdb_value,
  input  logic                                   cqdb_valid,
  output logic                                   cqdb_ready,
  input  logic [15:0]                            cqdb_value,
  output logic [NM_ADDR_WIDTH-1:0]               nm_awaddr,
  output logic [7:0]                             nm_awlen,
  output logic [2:0]                             nm_awsize,
  output logic [1:0]                             nm_awburst,
  output logic                                   nm_awvalid,
  input  logic                                   nm_awready,
  output logic [NM_DATA_WIDTH-1:0]               nm_wdata,
  output logic [NM_DATA_WIDTH/8-1:0]             nm_wstrb,
  output logic                                   nm_wlast,
  output logic                                   nm_wvalid,
  input  logic                                   nm_wready,
  input  logic [1:0]                             nm_bresp,
  input  logic                                   nm_bvalid,
  output logic                                   nm_bready,
  output logic [NM_ADDR_WIDTH-1:0]               nm_araddr,
  output logic [7:0]                             nm_arlen,
  output logic [2:0]                             nm_arsize,
  output logic [1:0]                             nm_arburst,
  output logic                                   nm_arvalid,
  output logic                                   nm_rready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   bresp_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = NM_DATA_WIDTH / 8;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [NUM_DB-1:0]       db_valid, db_ready, pending, grant;
  logic [NUM_DB-1:0][15:0] db_value, db_stored;

  arb_state_e state, state_n;
  db_id_e     gid;
  logic       prefer_cq, aw_done, w_done, aw_hs, w_hs, b_hs, issue_done;

  logic [NM_ADDR_WIDTH-1:0] issue_addr, sel_addr;
  logic [NM_DATA_WIDTH-1:0] issue_data, sel_data;
  logic [SW-1:0]            issue_strb, sel_strb;
  logic [1:0]               sel_lane;

  assign db_valid   = {cqdb_valid, sqdb_valid};
  assign db_value   = {cqdb_value, sqdb_value};
  assign sqdb_ready = db_ready[0];
  assign cqdb_ready = db_ready[1];

  // An accept in the grant cycle wins over the clear, so it becomes a fresh pending entry.
  for (genvar i = 0; i < NUM_DB; i++) begin : g_slot
    logic        pend_q, acc;
    logic [15:0] val_q;
`ifdef DB_COALESCE_EN
    assign db_ready[i] = 1'b1;
`else
    assign db_ready[i] = ~pend_q;
`endif
    assign acc = db_valid[i] & db_ready[i];
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        pend_q <= 1'b0;
        val_q  <= '0;
      end else if (acc) begin
        pend_q <= 1'b1;
        val_q  <= db_value[i];
      end else if (grant[i]) begin
        pend_q <= 1'b0;
      end
    end
    assign pending[i]   = pend_q;
    assign db_stored[i] = val_q;
  end

  always_comb begin
    state_n    = state;
    grant      = '0;
    issue_done = 1'b0;
    gid        = DB_SQ;
    aw_hs      = nm_awvalid & nm_awready;
    w_hs       = nm_wvalid & nm_wready;
    if (pending[1] && (!pending[0] || prefer_cq)) gid = DB_CQ;
    if (state == IDLE) begin
      if ((|pending) && (outstanding < MAX_CNT)) begin
        grant   = (gid == DB_CQ) ? 2'b10 : 2'b01;
        state_n = ISSUE;
      end
    end else if ((aw_done | aw_hs) && (w_done | w_hs)) begin
      issue_done = 1'b1;
      state_n    = IDLE;
    end
  end

  always_comb begin
    sel_addr = (gid == DB_CQ) ? NM_ADDR_WIDTH'(CQ_DB_ADDR) : NM_ADDR_WIDTH'(SQ_DB_ADDR);
    sel_lane = sel_addr[3:2];
    sel_data = NM_DATA_WIDTH'(db_stored[gid]) << (32 * sel_lane);
    sel_strb = SW'(4'hF) << (4 * sel_lane);
  end

  assign b_hs = nm_bvalid & nm_bready;

  // The round-robin pointer only moves on contested grants; a lone request leaves it alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      prefer_cq   <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      issue_addr  <= '0;
      issue_data  <= '0;
      issue_strb  <= '0;
      outstanding <= '0;
      bresp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (|grant) begin
        issue_addr <= sel_addr;
        issue_data <= sel_data;
        issue_strb <= sel_strb;
        if (&pending) prefer_cq <= (gid == DB_SQ);
      end
      if (issue_done) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (issue_done && !b_hs)      outstanding <= outstanding + 1'b1;
      else if (!issue_done && b_hs) outstanding <= outstanding - 1'b1;
      if (nm_bvalid && (nm_bresp != AXI_RESP_OKAY)) bresp_err <= 1'b1;
    end
  end

  assign nm_awvalid = (state == ISSUE) & ~aw_done;
  assign nm_wvalid  = (state == ISSUE) & ~w_done;
  assign nm_awaddr  = issue_addr;
  assign nm_awlen   = 8'd0;
  assign nm_awsize  = AXI_SIZE_4B;
  assign nm_awburst = AXI_BURST_INCR;
  assign nm_wdata   = issue_data;
  assign nm_wstrb   = issue_strb;
  assign nm_wlast   = nm_wvalid;
  assign nm_bready  = 1'b1;

  assign nm_araddr  = '0;
  assign nm_arlen   = 8'd0;
  assign nm_arsize  = 3'd0;
  assign nm_arburst = 2'd0;
  assign nm_arvalid = 1'b0;
  assign nm_rready  = 1'b0;

endmodule

// File: doc/doorbell_arbiter.md
DOORBELL_ARBITER -- requirements
Module: doorbell_arbiter

Interface
REQ-001 SHALL have parameter NM_ADDR_WIDTH, default 32, meaning NVMe BAR AXI address width.
REQ-002 SHALL have parameter NM_DATA_WIDTH, default 128, meaning NVMe BAR AXI data width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of unacknowledged doorbell writes.
REQ-004 SHALL have parameter SQ_DB_ADDR, default 1008, meaning the SQ1 tail doorbell byte address.
REQ-005 SHALL have parameter CQ_DB_ADDR, default 1012, meaning the CQ1 head doorbell byte address.
REQ-006 SHALL have the following ports:
- clk  in  1  clock; one clock domain.
- rstn  in  1  asynchronous, active-low reset.
- sqdb_valid/sqdb_ready  in/out  1/1  SQ tail doorbell request handshake.
- sqdb_value  in  16  new SQ tail value.
- cqdb_valid/cqdb_ready  in/out  1/1  CQ head doorbell request handshake.
- cqdb_value  in  16  new CQ head value.
- nm_aw*  out/in  AXI4 write-address channel (addr, len, size, burst, valid, ready).
- nm_w*  out/in  AXI4 write-data channel (data, strb, last, valid, ready).
- nm_b*  in/out  AXI4 write-response channel (resp, valid, ready).
- nm_ar*/nm_r*  out  read channels, tied off: arvalid=0, rready=0, other outputs 0.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  count of unacknowledged writes.
- bresp_err  out  1  sticky flag for a non-OKAY write response.

Function
REQ-007 SHALL keep one pending flag and one 16-bit value register per doorbell; a request is accepted on valid&ready, which sets the pending flag and stores the value.
REQ-008 SHALL use an FSM with states IDLE and ISSUE.
- IDLE with at least one pending doorbell and outstanding<MAX_OUTSTANDING: grant one doorbell, latch its address and value into issue registers, clear its pending flag, go to ISSUE.
REQ-009 SHALL arbitrate round-robin when both doorbells are pending: grant the doorbell not granted last; after reset, SQ has priority.
REQ-010 SHALL in ISSUE drive nm_awvalid and nm_wvalid together, each dropped independently once its own handshake completes.
- Return to IDLE in the cycle the last of the two handshakes completes, including when both complete in the same cycle.
REQ-011 SHALL drive the write beat as follows:
- awlen=0, awsize=2, awburst=1 (INCR), wlast=1.
- lane = addr[3:2]; wdata[32*lane +: 32] = zero-extended value; all other data bits 0.
- wstrb = 4'hF << (4*lane).
REQ-012 SHALL hold the address and data of the beat stable from first assertion of valid until its handshake.
REQ-013 SHALL have a latency of exactly 2 cycles: a request accepted in cycle N, with an idle arbiter and free credit, asserts nm_awvalid in cycle N+2.
REQ-014 SHALL increment outstanding on ISSUE exit and decrement it on nm_bvalid&nm_bready; when both happen in the same cycle, the count is unchanged.
REQ-015 SHALL tie nm_bready to 1, and SHALL NOT grant while outstanding==MAX_OUTSTANDING.
REQ-016 SHALL set bresp_err on any nm_bvalid with nm_bresp!=0; the flag clears only on reset.
REQ-017 SHALL apply a request accepted in the same cycle its doorbell is granted as a new pending entry; the granted issue-register value is unaffected.

Reset
REQ-018 SHALL on rstn low, asynchronously, reset all of the following:
- FSM to IDLE and pending flags to 0.
- outstanding to 0 and bresp_err to 0.
- round-robin pointer to SQ-first.
- nm_awvalid and nm_wvalid to 0; all data outputs to 0.
REQ-019 SHALL, on reset mid-ISSUE, abandon the in-flight beat without completing it.

Configuration
REQ-020 SHALL with DB_COALESCE_EN defined hold sqdb_ready=cqdb_ready=1 always; a request to an already-pending doorbell overwrites the stored value, so only the newest value is written.
REQ-021 SHALL with DB_COALESCE_EN undefined drive xxdb_ready = ~pending for that doorbell, so every accepted value is written exactly once in order.

Structure
REQ-022 SHALL place the FSM state enum, doorbell-ID enum and AXI constants (burst INCR, size 4B, OKAY response) in shared package nvme_drv_pkg.
REQ-023 SHALL instantiate no sub-modules; the two pending-register slots are generated by a loop over doorbell ID.

Verification
REQ-024 SHALL cover single SQ request: sqdb_value=5 -> one AW at 1008, wdata[31:0]=5, wstrb=16'h000F, awvalid asserted 2 cycles after acceptance.
REQ-025 SHALL cover simultaneous SQ=3 and CQ=7: SQ written first at 1008, then CQ at 1012 with wdata[63:32]=7 and wstrb=16'h00F0; the next simultaneous pair is CQ first.
REQ-026 SHALL cover the credit limit: hold nm_bvalid low with MAX_OUTSTANDING=4 -> exactly 4 AWs issued, the 5th waits until one B handshake, and outstanding peaks at 4.
REQ-027 SHALL cover AW/W skew: nm_awready delayed 3 cycles while nm_wready is immediate -> wvalid drops after 1 cycle, awvalid holds 3 cycles, and one beat is issued.
REQ-028 SHALL cover coalescing: with the macro on, SQ values 1, 2, 3 sent back-to-back while nm_awready=0 -> issued values are 1 then 3; with the macro off -> 1, 2, 3 with ready stalls.
REQ-029 SHALL cover error and reset: nm_bresp=2 -> bresp_err=1 until rstn pulse, and rstn asserted mid-ISSUE -> awvalid=0 immediately and outstanding=0.
